// File: rtl/mux_pkg.sv
// Shared definitions for the multi-cycle CPU datapath selectors.
// Defaults and the select encodings used by the PC and ALU source muxes.
package mux_pkg;

  localparam int WIDTH_DEF     = 32;
  localparam int CONST_VAL_DEF = 4;

  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'd0,
    PCSRC_ALUOUT = 2'd1,
    PCSRC_JUMP   = 2'd2
  } pcsrc_e;

  typedef enum logic [1:0] {
    ALUSRCB_REG   = 2'd0,
    ALUSRCB_FOUR  = 2'd1,
    ALUSRCB_IMM   = 2'd2,
    ALUSRCB_SHIMM = 2'd3
  } alusrcb_e;

endpackage

// File: rtl/mux_n_comb.sv
// Pure combinational N-way selector; out-of-range selects fall back to channel 0.
// With MUX_N_REG_CONST_EN defined, channel 1 is the constant CONST_VAL.
module mux_n_comb
  import mux_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int NUM_IN    = 4,
  parameter int SEL_W     = 2,
  parameter int CONST_VAL = CONST_VAL_DEF
) (
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        out_data,
  output logic                    illegal
);

  logic [WIDTH-1:0] chan [NUM_IN];

  for (genvar k = 0; k < NUM_IN; k++) begin : g_chan
`ifdef MUX_N_REG_CONST_EN
    if (k == 1) begin : g_const
      assign chan[k] = WIDTH'(CONST_VAL);
    end else begin : g_data
      assign chan[k] = in_data[k*WIDTH +: WIDTH];
    end
`else
    assign chan[k] = in_data[k*WIDTH +: WIDTH];
`endif
  end

  // NOTE: defaults come first so every path assigns both outputs and no latch is inferred.
  always_comb begin
    out_data = chan[0];
    illegal  = 1'b1;
    for (int k = 0; k < NUM_IN; k++) begin
      if (sel == SEL_W'(k)) begin
        out_data = chan[k];
        illegal  = 1'b0;
      end
    end
  end

endmodule

// File: rtl/mux_n_reg.sv
// N-input selector with one registered output slot, valid/ready handshake,
// sticky illegal-select flag and transfer counter. Option: MUX_N_REG_CONST_EN.
module mux_n_reg
  import mux_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int NUM_IN    = 4,
  parameter int SEL_W     = 2,
  parameter int CONST_VAL = CONST_VAL_DEF,
  parameter int CNT_W     = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sel_err,
  input  logic                    clr_err,
  output logic [CNT_W-1:0]        xfer_cnt
);

  if (NUM_IN < 2 || NUM_IN > 16 || (2**SEL_W) < NUM_IN) begin : g_param_check
    $error("mux_n_reg: NUM_IN must be 2..16 and fit in SEL_W bits");
  end

  logic [WIDTH-1:0] sel_data;
  logic             sel_illegal;
  logic             accept;

  mux_n_comb #(
    .WIDTH    (WIDTH),
    .NUM_IN   (NUM_IN),
    .SEL_W    (SEL_W),
    .CONST_VAL(CONST_VAL)
  ) u_sel (
    .in_data (in_data),
    .sel     (sel),
    .out_data(sel_data),
    .illegal (sel_illegal)
  );

  // The slot can take a new value when empty or when it is drained this cycle.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      xfer_cnt  <= '0;
    end else if (accept) begin
      out_data  <= sel_data;
      out_valid <= 1'b1;
      xfer_cnt  <= xfer_cnt + 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // An erroring accept wins over a coincident clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_err <= 1'b0;
    end else if (accept && sel_illegal) begin
      sel_err <= 1'b1;
    end else if (clr_err) begin
      sel_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_n_reg.sv
// Self-checking bench: a 4-input and a 3-input instance share one stimulus stream
// and are compared every cycle against a transaction-level model of the handshake.
module tb_mux_n_reg;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [4*W-1:0] in_data;
  logic [1:0]    sel;
  logic          in_valid, out_ready, clr_err;

  logic          in_ready4, out_valid4, sel_err4;
  logic [W-1:0]  out_data4;
  logic [15:0]   xfer_cnt4;
  logic          in_ready3, out_valid3, sel_err3;
  logic [W-1:0]  out_data3;
  logic [2:0]    xfer_cnt3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mux_n_reg #(.WIDTH(W), .NUM_IN(4), .SEL_W(2), .CONST_VAL(4), .CNT_W(16)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .sel(sel), .in_valid(in_valid),
    .in_ready(in_ready4), .out_data(out_data4), .out_valid(out_valid4),
    .out_ready(out_ready), .sel_err(sel_err4), .clr_err(clr_err), .xfer_cnt(xfer_cnt4)
  );

  mux_n_reg #(.WIDTH(W), .NUM_IN(3), .SEL_W(2), .CONST_VAL(4), .CNT_W(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data[3*W-1:0]), .sel(sel), .in_valid(in_valid),
    .in_ready(in_ready3), .out_data(out_data3), .out_valid(out_valid3),
    .out_ready(out_ready), .sel_err(sel_err3), .clr_err(clr_err), .xfer_cnt(xfer_cnt3)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int            num_in [2] = '{4, 3};
  int            cnt_mod[2] = '{65536, 8};
  bit            m_valid[2];
  logic [W-1:0]  m_data [2];
  bit            m_err  [2];
  int            m_cnt  [2];

  function automatic logic [W-1:0] channel(input int k);
`ifdef MUX_N_REG_CONST_EN
    if (k == 1) return 32'd4;
`endif
    return in_data[k*W +: W];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        m_valid[d] = 0; m_data[d] = '0; m_err[d] = 0; m_cnt[d] = 0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        bit take;
        bit legal;
        take  = in_valid && (!m_valid[d] || out_ready);
        legal = int'(sel) < num_in[d];
        if (clr_err) m_err[d] = 0;
        if (take) begin
          m_data[d]  = legal ? channel(int'(sel)) : channel(0);
          m_valid[d] = 1;
          m_cnt[d]   = (m_cnt[d] + 1) % cnt_mod[d];
          if (!legal) m_err[d] = 1;
        end else if (out_ready) begin
          m_valid[d] = 0;
        end
      end
    end
  end

  // Per-cycle comparison, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      check("in_ready4",  32'(in_ready4),  32'(!m_valid[0] || out_ready));
      check("out_valid4", 32'(out_valid4), 32'(m_valid[0]));
      check("sel_err4",   32'(sel_err4),   32'(m_err[0]));
      check("xfer_cnt4",  32'(xfer_cnt4),  32'(m_cnt[0]));
      if (m_valid[0]) check("out_data4", out_data4, m_data[0]);
      check("in_ready3",  32'(in_ready3),  32'(!m_valid[1] || out_ready));
      check("out_valid3", 32'(out_valid3), 32'(m_valid[1]));
      check("sel_err3",   32'(sel_err3),   32'(m_err[1]));
      check("xfer_cnt3",  32'(xfer_cnt3),  32'(m_cnt[1]));
      if (m_valid[1]) check("out_data3", out_data3, m_data[1]);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed + random stimulus ----------------
  logic [W-1:0] lit [4];
  logic [W-1:0] const_exp;

  initial begin
    lit[0] = 32'h11;
    lit[1] = 32'h22;
    lit[2] = 32'h33;
    lit[3] = 32'h44;
`ifdef MUX_N_REG_CONST_EN
    lit[1]    = 32'h4;
    const_exp = 32'h0000_0004;
`else
    const_exp = 32'h0000_DEAD;
`endif
    rst_n = 1'b0; in_valid = 0; out_ready = 0; clr_err = 0; sel = '0;
    in_data = {32'h44, 32'h33, 32'h22, 32'h11};
    #3;
    check("rst out_valid", 32'(out_valid4), 32'd0);
    check("rst out_data",  out_data4,       32'd0);
    check("rst xfer_cnt",  32'(xfer_cnt4),  32'd0);
    #5;
    rst_n = 1'b1;

    // basic select
    in_valid = 1; sel = 2'd2; out_ready = 1;
    step();
    check("basic data",  out_data4,       32'h33);
    check("basic valid", 32'(out_valid4), 32'd1);
    check("basic cnt",   32'(xfer_cnt4),  32'd1);

    // backpressure
    sel = 2'd3;
    step();
    check("bp first", out_data4, 32'h44);
    out_ready = 0; sel = 2'd0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp in_ready", 32'(in_ready4), 32'd0);
      check("bp hold",     out_data4,      32'h44);
    end
    check("bp cnt", 32'(xfer_cnt4), 32'd2);
    out_ready = 1;
    #1;
    check("bp release ready", 32'(in_ready4), 32'd1);
    step();
    check("bp next", out_data4, 32'h11);

    // full throughput
    for (int i = 0; i < 8; i++) begin
      sel = 2'(i % 4);
      step();
      check("tput data",  out_data4,       lit[i % 4]);
      check("tput valid", 32'(out_valid4), 32'd1);
    end
    check("tput cnt", 32'(xfer_cnt4), 32'd11);

    // illegal select on the 3-input instance
    sel = 2'd3;
    step();
    check("illegal data", out_data3,      32'h11);
    check("illegal err",  32'(sel_err3),  32'd1);
    check("legal no err", 32'(sel_err4),  32'd0);
    in_valid = 0; clr_err = 1;
    step();
    check("clr err", 32'(sel_err3), 32'd0);
    in_valid = 1; sel = 2'd3;
    step();
    check("clr vs set", 32'(sel_err3), 32'd1);
    out_ready = 0;
    step();
    check("stalled sel ignored", 32'(sel_err3), 32'd0);
    clr_err = 0;
    step();
    check("stalled stays clear", 32'(sel_err3), 32'd0);

    // constant channel
    out_ready = 1; sel = 2'd1;
    in_data[1*W +: W] = 32'hDEAD;
    step();
    check("const ch1", out_data4, const_exp);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      clr_err   = ($urandom_range(0, 7) == 0);
      sel       = 2'($urandom_range(0, 3));
      in_data   = {$urandom, $urandom, $urandom, $urandom};
      step();
    end

    // asynchronous reset while holding data
    clr_err = 0; in_valid = 1; out_ready = 1; sel = 2'd3;
    step();
    out_ready = 0;
    #2;
    rst_n = 1'b0;
    #1;
    check("mid rst valid", 32'(out_valid4), 32'd0);
    check("mid rst data",  out_data4,       32'd0);
    check("mid rst err3",  32'(sel_err3),   32'd0);
    check("mid rst cnt",   32'(xfer_cnt4),  32'd0);
    @(negedge clk);
    rst_n = 1'b1; in_valid = 0;
    step();
    check("post rst valid", 32'(out_valid4), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
